// File: rtl/interconn_arb_if.sv
// interconn_arb_if
// Bundles the sender-side and receiver-side bus signals of the MVU-to-MVU
// interconnect so that a single port carries them.
//   send_to   : N*N    field i = destination mask of sender i
//   send_en   : N      sender i presents a word
//   send_rdy  : N      sender i FIFO has room
//   send_addr : N*BADDR field i = target address
//   send_word : N*W    field i = data
//   recv_rdy  : N      receiver j can accept this cycle
//   recv_from : N*N    field j = one-hot source of delivered word
//   recv_en   : N      receiver j write strobe
//   recv_addr : N*BADDR field j = address
//   recv_word : N*W    field j = data
// The master modport is the MVU side (drives sends, consumes deliveries);
// the slave modport is the interconnect itself.
interface interconn_arb_if #(
  parameter int N     = 8,
  parameter int W     = 64,
  parameter int BADDR = 15
);
  logic [N*N-1:0]     send_to;
  logic [N-1:0]       send_en;
  logic [N-1:0]       send_rdy;
  logic [N*BADDR-1:0] send_addr;
  logic [N*W-1:0]     send_word;
  logic [N-1:0]       recv_rdy;
  logic [N*N-1:0]     recv_from;
  logic [N-1:0]       recv_en;
  logic [N*BADDR-1:0] recv_addr;
  logic [N*W-1:0]     recv_word;

  modport master (
    output send_to, send_en, send_addr, send_word, recv_rdy,
    input  send_rdy, recv_from, recv_en, recv_addr, recv_word
  );

  modport slave (
    input  send_to, send_en, send_addr, send_word, recv_rdy,
    output send_rdy, recv_from, recv_en, recv_addr, recv_word
  );
endinterface

// File: rtl/interconn_arb.sv
// interconn_arb
// N-port MVU-to-MVU interconnect. Every sender owns a DEPTH-entry FIFO whose
// head word may target several receivers at once (multicast). Every receiver
// runs its own round-robin arbiter over the sender heads that still owe it a
// copy. Deliveries are registered, one word per receiver per cycle.
// Ports:
//   clk   : clock
//   clr_n : asynchronous active-low reset
//   bus   : interconn_arb_if.slave, all send/receive bus signals
module interconn_arb #(
  parameter int N     = 8,
  parameter int W     = 64,
  parameter int BADDR = 15,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            clr_n,
  interconn_arb_if.slave bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // FIFO storage is not reset; the counts make stale entries invisible.
  logic [N-1:0]     fifoMask_q [N][DEPTH];
  logic [BADDR-1:0] fifoAddr_q [N][DEPTH];
  logic [W-1:0]     fifoWord_q [N][DEPTH];

  logic [AW-1:0] wrPtr_q [N];
  logic [AW-1:0] wrPtr_d [N];
  logic [AW-1:0] rdPtr_q [N];
  logic [AW-1:0] rdPtr_d [N];
  logic [CW-1:0] count_q [N];
  logic [CW-1:0] count_d [N];
  // Destinations already served for the current head; the pending mask is
  // the head mask minus these bits, so a fresh head starts fully pending.
  logic [N-1:0]  served_q [N];
  logic [N-1:0]  served_d [N];
  logic [PW-1:0] rrPtr_q [N];
  logic [PW-1:0] rrPtr_d [N];
  logic          ready_q;

  logic [N-1:0]       recvEn_q, recvEn_d;
  logic [N*N-1:0]     recvFrom_q, recvFrom_d;
  logic [N*BADDR-1:0] recvAddr_q, recvAddr_d;
  logic [N*W-1:0]     recvWord_q, recvWord_d;

  logic [N-1:0]  headValid;
  logic [N-1:0]  sendRdy;
  logic [N-1:0]  push;
  logic [N-1:0]  pop;
  logic [N-1:0]  pend [N];
  logic [N-1:0]  grant [N];
  logic [N-1:0]  grantAny;
  logic [PW-1:0] grantIdx [N];

  // send_rdy is held low until the first edge after reset release. Words
  // with an empty mask are accepted but never written.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      headValid[i] = (count_q[i] != '0);
      sendRdy[i]   = ready_q && (count_q[i] != FULL);
      push[i]      = bus.send_en[i] && sendRdy[i] && (bus.send_to[i*N +: N] != '0);
      pend[i]      = headValid[i] ? (fifoMask_q[i][rdPtr_q[i]] & ~served_q[i]) : '0;
    end
  end

  // Round-robin per receiver: first requester at or after rrPtr wins.
  always_comb begin
    logic [PW-1:0] cand;
    int            idx;
    cand = '0;
    idx  = 0;
    for (int j = 0; j < N; j++) begin
      grant[j]    = '0;
      grantAny[j] = 1'b0;
      grantIdx[j] = '0;
      rrPtr_d[j]  = rrPtr_q[j];
      for (int k = 0; k < N; k++) begin
        idx = int'(rrPtr_q[j]) + k;
        if (idx >= N) idx = idx - N;
        cand = PW'(idx);
        if (!grantAny[j] && bus.recv_rdy[j] && pend[cand][j]) begin
          grantAny[j]    = 1'b1;
          grantIdx[j]    = cand;
          grant[j][cand] = 1'b1;
        end
      end
      if (grantAny[j]) begin
        rrPtr_d[j] = (int'(grantIdx[j]) == N - 1) ? '0 : grantIdx[j] + PW'(1);
      end
    end
  end

  // A head pops on the edge where its last pending destination is granted;
  // the served mask clears on that same edge so the next head is live at once.
  always_comb begin
    logic [N-1:0] cleared;
    cleared = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        cleared[j] = grant[j][i];
      end
      pop[i]      = headValid[i] && ((pend[i] & ~cleared) == '0);
      served_d[i] = pop[i] ? '0 : (served_q[i] | cleared);
      count_d[i]  = count_q[i] + CW'(push[i]) - CW'(pop[i]);
      wrPtr_d[i]  = push[i] ? wrPtr_q[i] + AW'(1) : wrPtr_q[i];
      rdPtr_d[i]  = pop[i] ? rdPtr_q[i] + AW'(1) : rdPtr_q[i];
    end
  end

  // Delivery fields are zero on any cycle without a grant.
  always_comb begin
    recvEn_d   = grantAny;
    recvFrom_d = '0;
    recvAddr_d = '0;
    recvWord_d = '0;
    for (int j = 0; j < N; j++) begin
      if (grantAny[j]) begin
        recvFrom_d[j*N +: N]         = grant[j];
        recvAddr_d[j*BADDR +: BADDR] = fifoAddr_q[grantIdx[j]][rdPtr_q[grantIdx[j]]];
        recvWord_d[j*W +: W]         = fifoWord_q[grantIdx[j]][rdPtr_q[grantIdx[j]]];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (push[i]) begin
        fifoMask_q[i][wrPtr_q[i]] <= bus.send_to[i*N +: N];
        fifoAddr_q[i][wrPtr_q[i]] <= bus.send_addr[i*BADDR +: BADDR];
        fifoWord_q[i][wrPtr_q[i]] <= bus.send_word[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ready_q    <= 1'b0;
      recvEn_q   <= '0;
      recvFrom_q <= '0;
      recvAddr_q <= '0;
      recvWord_q <= '0;
      for (int i = 0; i < N; i++) begin
        wrPtr_q[i]  <= '0;
        rdPtr_q[i]  <= '0;
        count_q[i]  <= '0;
        served_q[i] <= '0;
        rrPtr_q[i]  <= '0;
      end
    end else begin
      ready_q    <= 1'b1;
      recvEn_q   <= recvEn_d;
      recvFrom_q <= recvFrom_d;
      recvAddr_q <= recvAddr_d;
      recvWord_q <= recvWord_d;
      for (int i = 0; i < N; i++) begin
        wrPtr_q[i]  <= wrPtr_d[i];
        rdPtr_q[i]  <= rdPtr_d[i];
        count_q[i]  <= count_d[i];
        served_q[i] <= served_d[i];
        rrPtr_q[i]  <= rrPtr_d[i];
      end
    end
  end

  assign bus.send_rdy  = sendRdy;
  assign bus.recv_en   = recvEn_q;
  assign bus.recv_from = recvFrom_q;
  assign bus.recv_addr = recvAddr_q;
  assign bus.recv_word = recvWord_q;

endmodule

// File: tb/tb_interconn_arb.sv
// tb_interconn_arb
// Directed bench for interconn_arb: a table of single-sender transfers
// (unicast sweep, loopback, multicast) plus hand-written sequences for
// contention, multicast contention, backpressure, zero masks and async reset.
module tb_interconn_arb;

  localparam int N = 8;
  localparam int W = 64;
  localparam int BADDR = 15;

  logic clk;
  logic clr_n;
  int   errors;
  int   checks;

  interconn_arb_if #(.N(N), .W(W), .BADDR(BADDR)) bus ();

  interconn_arb #(.N(N), .W(W), .BADDR(BADDR), .DEPTH(4)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int          src;
    logic [7:0]  mask;
    logic [14:0] addr;
    logic [63:0] word;
    logic [7:0]  expEn;
  } vec_t;

  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    bus.send_en   = '0;
    bus.send_to   = '0;
    bus.send_addr = '0;
    bus.send_word = '0;
  endtask

  task automatic applyReset();
    clr_n = 1'b0;
    clearInputs();
    bus.recv_rdy = '1;
    tick();
    tick();
    checkOutput("rst_send_rdy", 64'(bus.send_rdy), 64'h0);
    checkOutput("rst_recv_en", 64'(bus.recv_en), 64'h0);
    checkOutput("rst_recv_from", bus.recv_from, 64'h0);
    clr_n = 1'b1;
    tick();
    checkOutput("rel_send_rdy", 64'(bus.send_rdy), 64'hff);
  endtask

  task automatic setSend(input int s, input logic [7:0] mask, input logic [14:0] addr,
                         input logic [63:0] word);
    bus.send_en[s]             = 1'b1;
    bus.send_to[s*N +: N]      = mask;
    bus.send_addr[s*BADDR +: BADDR] = addr;
    bus.send_word[s*W +: W]    = word;
  endtask

  // One transfer with no contention: accepted at edge k, delivered after k+1.
  task automatic applyStimulus(input vec_t v);
    logic [63:0] expFrom;
    clearInputs();
    setSend(v.src, v.mask, v.addr, v.word);
    checkOutput("tbl_send_rdy", 64'(bus.send_rdy[v.src]), 64'h1);
    tick();
    clearInputs();
    tick();
    checkOutput("tbl_recv_en", 64'(bus.recv_en), 64'(v.expEn));
    expFrom = '0;
    for (int j = 0; j < N; j++) begin
      if (v.expEn[j]) begin
        expFrom[j*N +: N] = 8'd1 << v.src;
        checkOutput("tbl_addr", 64'(bus.recv_addr[j*BADDR +: BADDR]), 64'(v.addr));
        checkOutput("tbl_word", bus.recv_word[j*W +: W], v.word);
      end
    end
    checkOutput("tbl_recv_from", bus.recv_from, expFrom);
    tick();
    checkOutput("tbl_one_cycle", 64'(bus.recv_en), 64'h0);
  endtask

  // Single delivery expected on receiver dst from sender src, addr = src.
  task automatic expectRecv(input int dst, input int src);
    checkOutput("arb_recv_en", 64'(bus.recv_en), 64'(8'd1 << dst));
    checkOutput("arb_recv_from", 64'(bus.recv_from[dst*N +: N]), 64'(8'd1 << src));
    checkOutput("arb_recv_addr", 64'(bus.recv_addr[dst*BADDR +: BADDR]), 64'(src));
  endtask

  task automatic pushToZero(input logic [7:0] senders);
    clearInputs();
    for (int i = 0; i < N; i++) begin
      if (senders[i]) setSend(i, 8'h01, 15'(i), 64'(i));
    end
    tick();
    clearInputs();
  endtask

  initial begin
    vec_t v;
    errors = 0;
    checks = 0;
    clr_n  = 1'b0;
    clearInputs();
    bus.recv_rdy = '1;

    // Multicast and loopback first, then the full unicast sweep.
    v.src = 4; v.mask = 8'b10100001; v.addr = 15'h12; v.word = 64'h1; v.expEn = 8'b10100001;
    vecs.push_back(v);
    v.src = 5; v.mask = 8'h20; v.addr = 15'h3; v.word = 64'h55; v.expEn = 8'h20;
    vecs.push_back(v);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (i != j) begin
          v.src = i; v.mask = 8'd1 << j; v.addr = 15'd7;
          v.word = 64'hdeadbeefdeadbeef; v.expEn = 8'd1 << j;
          vecs.push_back(v);
        end
      end
    end

    $display("[TB] reset and table sweep");
    applyReset();
    foreach (vecs[n]) applyStimulus(vecs[n]);

    $display("[TB] contention on receiver 0");
    applyReset();
    pushToZero(8'b00100110);
    tick(); expectRecv(0, 1);
    tick(); expectRecv(0, 2);
    tick(); expectRecv(0, 5);
    tick(); checkOutput("arb_idle", 64'(bus.recv_en), 64'h0);
    // ptr[0] is now 6, so 7 wins over 5.
    pushToZero(8'b10100000);
    tick(); expectRecv(0, 7);
    tick(); expectRecv(0, 5);
    tick(); checkOutput("arb_idle2", 64'(bus.recv_en), 64'h0);
    // Single grant to 2 leaves ptr[0] at 3.
    pushToZero(8'b00000100);
    tick(); expectRecv(0, 2);
    pushToZero(8'b00100110);
    tick(); expectRecv(0, 5);
    tick(); expectRecv(0, 1);
    tick(); expectRecv(0, 2);
    tick(); checkOutput("arb_idle3", 64'(bus.recv_en), 64'h0);

    $display("[TB] multicast with contention on receiver 5");
    applyReset();
    clearInputs();
    setSend(4, 8'b10100001, 15'h12, 64'h1);
    setSend(3, 8'b00100000, 15'h33, 64'h3);
    tick();
    clearInputs();
    tick();
    checkOutput("mc_en1", 64'(bus.recv_en), 64'ha1);
    checkOutput("mc_from0", 64'(bus.recv_from[0 +: N]), 64'h10);
    checkOutput("mc_from5a", 64'(bus.recv_from[5*N +: N]), 64'h08);
    checkOutput("mc_from7", 64'(bus.recv_from[7*N +: N]), 64'h10);
    tick();
    checkOutput("mc_en2", 64'(bus.recv_en), 64'h20);
    checkOutput("mc_from5b", 64'(bus.recv_from[5*N +: N]), 64'h10);
    checkOutput("mc_addr5b", 64'(bus.recv_addr[5*BADDR +: BADDR]), 64'h12);
    tick();
    checkOutput("mc_en3", 64'(bus.recv_en), 64'h0);

    $display("[TB] backpressure on receiver 2");
    applyReset();
    bus.recv_rdy = 8'hfb;
    clearInputs();
    for (int n = 1; n <= 4; n++) begin
      setSend(0, 8'h04, 15'(n), 64'(n));
      checkOutput("bp_rdy_fill", 64'(bus.send_rdy[0]), 64'h1);
      tick();
    end
    setSend(0, 8'h04, 15'd5, 64'd5);
    checkOutput("bp_full", 64'(bus.send_rdy[0]), 64'h0);
    tick();
    checkOutput("bp_held", 64'(bus.send_rdy[0]), 64'h0);
    checkOutput("bp_stalled", 64'(bus.recv_en), 64'h0);
    bus.recv_rdy = 8'hff;
    checkOutput("bp_no_bypass", 64'(bus.send_rdy[0]), 64'h0);
    tick();
    checkOutput("bp_en_w1", 64'(bus.recv_en), 64'h04);
    checkOutput("bp_word_w1", bus.recv_word[2*W +: W], 64'd1);
    checkOutput("bp_rdy_back", 64'(bus.send_rdy[0]), 64'h1);
    tick();
    clearInputs();
    for (int n = 2; n <= 5; n++) begin
      checkOutput("bp_en_seq", 64'(bus.recv_en), 64'h04);
      checkOutput("bp_word_seq", bus.recv_word[2*W +: W], 64'(n));
      tick();
    end
    checkOutput("bp_done", 64'(bus.recv_en), 64'h0);
    checkOutput("bp_rdy_end", 64'(bus.send_rdy[0]), 64'h1);

    $display("[TB] zero destination mask");
    clearInputs();
    setSend(3, 8'h00, 15'h5, 64'hbad);
    checkOutput("zm_accept", 64'(bus.send_rdy[3]), 64'h1);
    tick();
    clearInputs();
    for (int n = 0; n < 3; n++) begin
      tick();
      checkOutput("zm_no_recv", 64'(bus.recv_en), 64'h0);
    end
    v.src = 3; v.mask = 8'h40; v.addr = 15'h21; v.word = 64'h1234; v.expEn = 8'h40;
    applyStimulus(v);

    $display("[TB] async reset mid-burst");
    applyReset();
    bus.recv_rdy = 8'hbf;
    for (int n = 0; n < 2; n++) begin
      clearInputs();
      for (int i = 0; i < 3; i++) setSend(i, 8'h40, 15'(i), 64'(n + 10));
      tick();
    end
    clearInputs();
    setSend(3, 8'h02, 15'h9, 64'h77);
    tick();
    clearInputs();
    tick();
    checkOutput("ar_inflight", 64'(bus.recv_en), 64'h02);
    #3;
    clr_n = 1'b0;
    #1;
    checkOutput("ar_en", 64'(bus.recv_en), 64'h0);
    checkOutput("ar_from", bus.recv_from, 64'h0);
    checkOutput("ar_addr", 64'(bus.recv_addr[1*BADDR +: BADDR]), 64'h0);
    checkOutput("ar_word", bus.recv_word[1*W +: W], 64'h0);
    checkOutput("ar_send_rdy", 64'(bus.send_rdy), 64'h0);
    #1;
    clr_n = 1'b1;
    bus.recv_rdy = 8'hff;
    tick();
    checkOutput("ar_rdy_rel", 64'(bus.send_rdy), 64'hff);
    checkOutput("ar_quiet0", 64'(bus.recv_en), 64'h0);
    for (int n = 0; n < 5; n++) begin
      tick();
      checkOutput("ar_quiet", 64'(bus.recv_en), 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
